// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default qualification window, so RTL and benches agree.
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } db_state_t;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// parameterised reset value so the output idles at the pin's inactive level.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: synchronised, qualified over DEBOUNCE_CYCLES
// consecutive samples, with registered level, press/release pulses and toggle.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic        BUTTON_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic buttonIn,
   output logic buttonClean,
   output logic pressPulse,
   output logic releasePulse,
   output logic toggleOut
);

   localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   // The entry cycle counts as the first sample, so acceptance happens when
   // the count is about to step onto DEBOUNCE_CYCLES-1.
   localparam logic [CNT_WIDTH-1:0] CNT_QUAL = CNT_WIDTH'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic                 sync_q;
   logic                 pressed;
   logic                 qualified;
   db_state_t            state, state_next;
   logic [CNT_WIDTH-1:0] cnt, cnt_next;
   logic                 clean_next, press_next, release_next, toggle_next;

   sync_2ff #(
      .RESET_VALUE(BUTTON_ACTIVE_LOW)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst),
      .d    (buttonIn),
      .q    (sync_q)
   );

   assign pressed   = sync_q ^ BUTTON_ACTIVE_LOW;
   assign qualified = (cnt == CNT_QUAL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RELEASED;
         cnt          <= '0;
         buttonClean  <= BUTTON_ACTIVE_LOW;
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
         toggleOut    <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         buttonClean  <= clean_next;
         pressPulse   <= press_next;
         releasePulse <= release_next;
         toggleOut    <= toggle_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = '0;
      press_next   = 1'b0;
      release_next = 1'b0;
      toggle_next  = toggleOut;
      unique case (state)
         RELEASED: begin
            if (pressed) state_next = PRESS_CHK;
         end
         PRESS_CHK: begin
            if (!pressed) begin
               state_next = RELEASED;
            end else if (qualified) begin
               state_next  = HELD;
               press_next  = 1'b1;
               toggle_next = ~toggleOut;
            end else begin
               cnt_next = (cnt == CNT_LAST) ? cnt : cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!pressed) state_next = RELEASE_CHK;
         end
         RELEASE_CHK: begin
            if (pressed) begin
               state_next = HELD;
            end else if (qualified) begin
               state_next   = RELEASED;
               release_next = 1'b1;
            end else begin
               cnt_next = (cnt == CNT_LAST) ? cnt : cnt + CNT_ONE;
            end
         end
      endcase
      // Active pin level is the inverse of BUTTON_ACTIVE_LOW.
      clean_next = ((state_next == HELD) || (state_next == RELEASE_CHK)) ^ BUTTON_ACTIVE_LOW;
   end

endmodule
